alu_issue_stage: RTL and testbench

//  Decode/issue stage driving the EX-stage ALU: turns a decoded-stage instruction word plus register-file read data

---
 rtl/alu_issue_stage_if.sv | 41 ++++
 rtl/alu_issue_stage.sv | 157 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// ID/EX handshake bundle for alu_issue_stage.
// The write-back forwarding signals exist only when FORWARD_EN is defined.
interface alu_issue_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic [31:0]   inst_d;
  logic          valid_d;
  logic          ready_d;
  logic [DW-1:0] rdata1_d;
  logic [DW-1:0] rdata2_d;
  logic          flush;
  logic          valid_e;
  logic          ready_e;
  logic [3:0]    aluop_e;
  logic [DW-1:0] alusrc1_e;
  logic [DW-1:0] alusrc2_e;
  logic [RW-1:0] ra_e;
  logic          we_e;
`ifdef FORWARD_EN
  logic          wb_en;
  logic [RW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
`endif

  modport master (
`ifdef FORWARD_EN
    output wb_en, wb_addr, wb_data,
`endif
    output inst_d, valid_d, rdata1_d, rdata2_d, flush, ready_e,
    input  ready_d, valid_e, aluop_e, alusrc1_e, alusrc2_e, ra_e, we_e
  );

  modport slave (
`ifdef FORWARD_EN
    input  wb_en, wb_addr, wb_data,
`endif
    input  inst_d, valid_d, rdata1_d, rdata2_d, flush, ready_e,
    output ready_d, valid_e, aluop_e, alusrc1_e, alusrc2_e, ra_e, we_e
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the EX ALU through a 2-entry skid-buffered ID/EX register.
// Optional feature: define FORWARD_EN to forward write-back data into decoded and held operands.
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic            clk,
  input logic            rst_n,
  alu_issue_stage_if.slave bus
);

  typedef struct packed {
    logic [3:0]    aluop;
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic [RW-1:0] ra;
    logic          we;
`ifdef FORWARD_EN
    logic [RW-1:0] rb;
    logic [RW-1:0] rc;
    logic          src1_reg;
    logic          src2_reg;
`endif
  } entry_t;

  logic [4:0]    op;
  logic [4:0]    ra_f;
  logic [4:0]    rb_f;
  logic [4:0]    rc_f;
  logic [16:0]   imm;
  logic          si;
  logic [4:0]    shamt;
  logic [DW-1:0] sext;
  logic [DW-1:0] opnd1;
  logic [DW-1:0] opnd2;
  logic [DW-1:0] shift_src2;
  entry_t        dec;
  entry_t        or_q;
  entry_t        sk_q;
  entry_t        or_hold;
  entry_t        sk_hold;
  logic          or_v;
  logic          sk_v;
  logic          accept;

  assign op    = bus.inst_d[31:27];
  assign ra_f  = bus.inst_d[26:22];
  assign rb_f  = bus.inst_d[21:17];
  assign rc_f  = bus.inst_d[16:12];
  assign imm   = bus.inst_d[16:0];
  assign si    = bus.inst_d[5];
  assign shamt = bus.inst_d[4:0];
  assign sext  = {{(DW-17){imm[16]}}, imm};

`ifdef FORWARD_EN
  logic src1_reg;
  logic src2_reg;

  // Same-cycle write-back wins over the register-file read of rb/rc, including r0.
  assign opnd1 = (bus.wb_en && bus.wb_addr == RW'(rb_f)) ? bus.wb_data : bus.rdata1_d;
  assign opnd2 = (bus.wb_en && bus.wb_addr == RW'(rc_f)) ? bus.wb_data : bus.rdata2_d;
  assign src1_reg = (op <= 5'd2) || ((op >= 5'd4) && (op <= 5'd14) && (op != 5'd6) && (op != 5'd7));
  assign src2_reg = ((op >= 5'd4) && (op <= 5'd10)) || ((op >= 5'd11) && (op <= 5'd14) && !si);

  function automatic entry_t fwd_entry(input entry_t e, input logic en,
                                       input logic [RW-1:0] addr, input logic [DW-1:0] data);
    fwd_entry = e;
    if (en && e.src1_reg && addr == e.rb) fwd_entry.src1 = data;
    if (en && e.src2_reg && addr == e.rc) fwd_entry.src2 = data;
  endfunction

  assign or_hold = fwd_entry(or_q, bus.wb_en, bus.wb_addr, bus.wb_data);
  assign sk_hold = fwd_entry(sk_q, bus.wb_en, bus.wb_addr, bus.wb_data);
`else
  logic unused_rb;

  assign opnd1     = bus.rdata1_d;
  assign opnd2     = bus.rdata2_d;
  assign unused_rb = ^rb_f;
  assign or_hold   = or_q;
  assign sk_hold   = sk_q;
`endif

  assign shift_src2 = si ? {{(DW-5){1'b0}}, shamt} : opnd2;

  // Instruction decode into the ALU entry; unknown ops become a non-writing bubble.
  always_comb begin
    dec    = '0;
    dec.ra = RW'(ra_f);
    dec.we = (op <= 5'd14);
`ifdef FORWARD_EN
    dec.rb       = RW'(rb_f);
    dec.rc       = RW'(rc_f);
    dec.src1_reg = src1_reg;
    dec.src2_reg = src2_reg;
`endif
    case (op)
      5'd0:  begin dec.aluop = 4'd1;  dec.src1 = opnd1; dec.src2 = sext;       end
      5'd1:  begin dec.aluop = 4'd5;  dec.src1 = opnd1; dec.src2 = sext;       end
      5'd2:  begin dec.aluop = 4'd6;  dec.src1 = opnd1; dec.src2 = sext;       end
      5'd3:  begin dec.aluop = 4'd12; dec.src2 = sext;                         end
      5'd4:  begin dec.aluop = 4'd1;  dec.src1 = opnd1; dec.src2 = opnd2;      end
      5'd5:  begin dec.aluop = 4'd2;  dec.src1 = opnd1; dec.src2 = opnd2;      end
      5'd6:  begin dec.aluop = 4'd3;  dec.src2 = opnd2;                        end
      5'd7:  begin dec.aluop = 4'd4;  dec.src2 = opnd2;                        end
      5'd8:  begin dec.aluop = 4'd5;  dec.src1 = opnd1; dec.src2 = opnd2;      end
      5'd9:  begin dec.aluop = 4'd6;  dec.src1 = opnd1; dec.src2 = opnd2;      end
      5'd10: begin dec.aluop = 4'd7;  dec.src1 = opnd1; dec.src2 = opnd2;      end
      5'd11: begin dec.aluop = 4'd8;  dec.src1 = opnd1; dec.src2 = shift_src2; end
      5'd12: begin dec.aluop = 4'd9;  dec.src1 = opnd1; dec.src2 = shift_src2; end
      5'd13: begin dec.aluop = 4'd10; dec.src1 = opnd1; dec.src2 = shift_src2; end
      5'd14: begin dec.aluop = 4'd11; dec.src1 = opnd1; dec.src2 = shift_src2; end
      default: begin end
    endcase
  end

  assign accept = bus.valid_d & ~sk_v;

  // OR/SK skid pair: SK only fills when OR is stalled, so FIFO order falls out naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
      or_q <= '0;
      sk_q <= '0;
    end else if (bus.flush) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
    end else if (!or_v || bus.ready_e) begin
      if (sk_v) begin
        or_q <= sk_hold;
        or_v <= 1'b1;
        sk_v <= 1'b0;
      end else begin
        or_v <= accept;
        if (accept) or_q <= dec;
      end
    end else begin
      or_q <= or_hold;
      if (accept) begin
        sk_q <= dec;
        sk_v <= 1'b1;
      end else begin
        sk_q <= sk_hold;
      end
    end
  end

  assign bus.ready_d   = ~sk_v;
  assign bus.valid_e   = or_v;
  assign bus.aluop_e   = or_q.aluop;
  assign bus.alusrc1_e = or_q.src1;
  assign bus.alusrc2_e = or_q.src2;
  assign bus.ra_e      = or_q.ra;
  assign bus.we_e      = or_q.we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions push expected ALU entries,
// a negedge monitor pops and compares every entry EX consumes.
module tb_alu_issue_stage;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  ra;
    logic        we;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    n_vec = 0;
  int    n_err = 0;
  exp_t  exp_q[$];
  exp_t  mon_e;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.DW(32), .RW(5)) bus ();

  alu_issue_stage #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] ra, input logic [4:0] rb,
                                     input logic [4:0] rc, input logic [11:0] low);
    mk = {op, ra, rb, rc, low};
  endfunction

  function automatic exp_t ex(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [4:0] ra, input logic we);
    ex.op = op; ex.s1 = s1; ex.s2 = s2; ex.ra = ra; ex.we = we;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Present one instruction until accepted (bounded); the expected entry is queued at acceptance.
  task automatic apply_stimulus(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                                input exp_t e);
    int waited = 0;
    bus.inst_d   = inst;
    bus.rdata1_d = r1;
    bus.rdata2_d = r2;
    bus.valid_d  = 1'b1;
    while (!bus.ready_d && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.ready_d) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL accept_timeout: inst %h not accepted within 20 cycles", inst);
    end else begin
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    bus.valid_d = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_output("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.valid_e && bus.ready_e) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_entry: got op=%0d src1=%h src2=%h ra=%0d we=%0d, required no entry",
                 bus.aluop_e, bus.alusrc1_e, bus.alusrc2_e, bus.ra_e, bus.we_e);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.aluop_e !== mon_e.op || bus.alusrc1_e !== mon_e.s1 || bus.alusrc2_e !== mon_e.s2 ||
            bus.ra_e !== mon_e.ra || bus.we_e !== mon_e.we) begin
          n_err++;
          $display("[TB] FAIL entry: got op=%0d src1=%h src2=%h ra=%0d we=%0d, required op=%0d src1=%h src2=%h ra=%0d we=%0d",
                   bus.aluop_e, bus.alusrc1_e, bus.alusrc2_e, bus.ra_e, bus.we_e,
                   mon_e.op, mon_e.s1, mon_e.s2, mon_e.ra, mon_e.we);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    bus.inst_d   = '0;
    bus.valid_d  = 1'b0;
    bus.rdata1_d = '0;
    bus.rdata2_d = '0;
    bus.flush    = 1'b0;
    bus.ready_e  = 1'b1;
`ifdef FORWARD_EN
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
`endif
    #3;
    check_output("rst_valid_e", 32'(bus.valid_e), 32'd0);
    check_output("rst_ready_d", 32'(bus.ready_d), 32'd1);
    check_output("rst_aluop_e", 32'(bus.aluop_e), 32'd0);
    check_output("rst_src1", bus.alusrc1_e, 32'd0);
    check_output("rst_src2", bus.alusrc2_e, 32'd0);
    check_output("rst_ra_we", {26'd0, bus.ra_e, bus.we_e}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode coverage with EX always ready
    apply_stimulus(32'h20C22000, 32'd5, 32'd7, ex(4'd1, 32'd5, 32'd7, 5'd3, 1'b1));
    check_output("latency_valid_e", 32'(bus.valid_e), 32'd1);
    apply_stimulus(32'h0045FFFF, 32'h10, 32'h55, ex(4'd1, 32'h10, 32'hFFFFFFFF, 5'd1, 1'b1));
    apply_stimulus(mk(5'd11, 5'd4, 5'd6, 5'd7, 12'h024), 32'h80000000, 32'h1234,
                   ex(4'd8, 32'h80000000, 32'd4, 5'd4, 1'b1));
    apply_stimulus(mk(5'd12, 5'd5, 5'd1, 5'd2, 12'h000), 32'hF0000000, 32'd3,
                   ex(4'd9, 32'hF0000000, 32'd3, 5'd5, 1'b1));
    apply_stimulus(mk(5'd14, 5'd6, 5'd1, 5'd2, 12'h03F), 32'hA5A5A5A5, 32'd0,
                   ex(4'd11, 32'hA5A5A5A5, 32'd31, 5'd6, 1'b1));
    apply_stimulus(mk(5'd13, 5'd7, 5'd1, 5'd2, 12'h01F), 32'h1, 32'hDEAD,
                   ex(4'd10, 32'h1, 32'hDEAD, 5'd7, 1'b1));
    apply_stimulus({5'd3, 5'd9, 5'd0, 17'h00123}, 32'h777, 32'h888, ex(4'd12, 32'd0, 32'h123, 5'd9, 1'b1));
    apply_stimulus({5'd1, 5'd2, 5'd3, 17'h0FFFF}, 32'h12345678, 32'h0, ex(4'd5, 32'h12345678, 32'h0000FFFF, 5'd2, 1'b1));
    apply_stimulus({5'd2, 5'd10, 5'd4, 17'h10000}, 32'h0000000F, 32'h0, ex(4'd6, 32'h0000000F, 32'hFFFF0000, 5'd10, 1'b1));
    apply_stimulus(mk(5'd5, 5'd13, 5'd1, 5'd2, 12'h0), 32'd100, 32'd30, ex(4'd2, 32'd100, 32'd30, 5'd13, 1'b1));
    apply_stimulus(mk(5'd6, 5'd8, 5'd1, 5'd2, 12'h0), 32'h11, 32'h22, ex(4'd3, 32'd0, 32'h22, 5'd8, 1'b1));
    apply_stimulus(mk(5'd7, 5'd14, 5'd1, 5'd2, 12'h0), 32'h11, 32'h33, ex(4'd4, 32'd0, 32'h33, 5'd14, 1'b1));
    apply_stimulus(mk(5'd8, 5'd15, 5'd1, 5'd2, 12'h0), 32'hFF00, 32'h0FF0, ex(4'd5, 32'hFF00, 32'h0FF0, 5'd15, 1'b1));
    apply_stimulus(mk(5'd9, 5'd16, 5'd1, 5'd2, 12'h0), 32'hFF00, 32'h0FF0, ex(4'd6, 32'hFF00, 32'h0FF0, 5'd16, 1'b1));
    apply_stimulus(mk(5'd10, 5'd17, 5'd1, 5'd2, 12'h0), 32'hFF00, 32'h0FF0, ex(4'd7, 32'hFF00, 32'h0FF0, 5'd17, 1'b1));
    apply_stimulus(mk(5'd31, 5'd11, 5'd1, 5'd2, 12'hFFF), 32'h5, 32'h6, ex(4'd0, 32'd0, 32'd0, 5'd11, 1'b0));
    apply_stimulus(mk(5'd15, 5'd12, 5'd1, 5'd2, 12'h0), 32'h5, 32'h6, ex(4'd0, 32'd0, 32'd0, 5'd12, 1'b0));
    wait_drain();

    // Backpressure: A held, B in skid, C stalls until EX frees space
    bus.ready_e = 1'b0;
    apply_stimulus(32'h20C22000, 32'd5, 32'd7, ex(4'd1, 32'd5, 32'd7, 5'd3, 1'b1));
    apply_stimulus(mk(5'd5, 5'd4, 5'd1, 5'd2, 12'h0), 32'd100, 32'd30, ex(4'd2, 32'd100, 32'd30, 5'd4, 1'b1));
    fork
      apply_stimulus(mk(5'd10, 5'd12, 5'd3, 5'd4, 12'h0), 32'hF0F0, 32'h0FF0,
                     ex(4'd7, 32'hF0F0, 32'h0FF0, 5'd12, 1'b1));
      begin
        repeat (3) @(posedge clk);
        #2;
        check_output("bp_ready_d", 32'(bus.ready_d), 32'd0);
        check_output("bp_valid_e", 32'(bus.valid_e), 32'd1);
        check_output("bp_hold_aluop", 32'(bus.aluop_e), 32'd1);
        check_output("bp_hold_src1", bus.alusrc1_e, 32'd5);
        check_output("bp_hold_src2", bus.alusrc2_e, 32'd7);
        check_output("bp_hold_ra", 32'(bus.ra_e), 32'd3);
        bus.ready_e = 1'b1;
      end
    join
    wait_drain();

    // Flush with OR and SK full while a new instruction is offered
    bus.ready_e = 1'b0;
    apply_stimulus(mk(5'd4, 5'd1, 5'd1, 5'd2, 12'h0), 32'd1, 32'd2, ex(4'd1, 32'd1, 32'd2, 5'd1, 1'b1));
    apply_stimulus(mk(5'd5, 5'd2, 5'd1, 5'd2, 12'h0), 32'd3, 32'd4, ex(4'd2, 32'd3, 32'd4, 5'd2, 1'b1));
    bus.inst_d  = mk(5'd9, 5'd3, 5'd1, 5'd2, 12'h0);
    bus.valid_d = 1'b1;
    bus.flush   = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    bus.flush   = 1'b0;
    bus.valid_d = 1'b0;
    check_output("flush_full_valid_e", 32'(bus.valid_e), 32'd0);
    check_output("flush_full_ready_d", 32'(bus.ready_d), 32'd1);

    // Flush with only OR full: the same-cycle accept must be dropped
    apply_stimulus(mk(5'd8, 5'd4, 5'd1, 5'd2, 12'h0), 32'd5, 32'd6, ex(4'd5, 32'd5, 32'd6, 5'd4, 1'b1));
    bus.inst_d  = mk(5'd10, 5'd5, 5'd1, 5'd2, 12'h0);
    bus.valid_d = 1'b1;
    bus.flush   = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    bus.flush   = 1'b0;
    bus.valid_d = 1'b0;
    bus.ready_e = 1'b1;
    check_output("flush_or_valid_e", 32'(bus.valid_e), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("flush_no_late_entry", 32'(bus.valid_e), 32'd0);

    // Asynchronous reset mid-transfer with both entries occupied
    bus.ready_e = 1'b0;
    apply_stimulus(mk(5'd4, 5'd6, 5'd1, 5'd2, 12'h0), 32'd9, 32'd9, ex(4'd1, 32'd9, 32'd9, 5'd6, 1'b1));
    apply_stimulus(mk(5'd4, 5'd7, 5'd1, 5'd2, 12'h0), 32'd8, 32'd8, ex(4'd1, 32'd8, 32'd8, 5'd7, 1'b1));
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_output("midrst_valid_e", 32'(bus.valid_e), 32'd0);
    check_output("midrst_aluop_e", 32'(bus.aluop_e), 32'd0);
    check_output("midrst_ready_d", 32'(bus.ready_d), 32'd1);
    check_output("midrst_we_e", 32'(bus.we_e), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.ready_e = 1'b1;
    apply_stimulus(mk(5'd9, 5'd20, 5'd1, 5'd2, 12'h0), 32'hAA, 32'h55, ex(4'd6, 32'hAA, 32'h55, 5'd20, 1'b1));
    wait_drain();

`ifdef FORWARD_EN
    // Write-back forwarding into decode and into a held entry
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd1;
    bus.wb_data = 32'h99;
    apply_stimulus(32'h20C22000, 32'd5, 32'd7, ex(4'd1, 32'h99, 32'd7, 5'd3, 1'b1));
    bus.wb_addr = 5'd0;
    apply_stimulus({5'd3, 5'd9, 5'd0, 17'h00042}, 32'h5, 32'h6, ex(4'd12, 32'd0, 32'h42, 5'd9, 1'b1));
    bus.wb_en   = 1'b0;
    wait_drain();
    bus.ready_e = 1'b0;
    apply_stimulus(32'h20C22000, 32'd5, 32'd7, ex(4'd1, 32'd5, 32'hABC, 5'd3, 1'b1));
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd2;
    bus.wb_data = 32'hABC;
    @(posedge clk); #1;
    bus.wb_en   = 1'b0;
    bus.ready_e = 1'b1;
    wait_drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
